// File: rtl/calc1_pkg.sv
// Shared encodings for the calc1 responder: commands, response codes, FSM states
// and the default response latency.
package calc1_pkg;

  localparam int DEFAULT_RESP_LATENCY = 3;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_OVF  = 2'b10;
  localparam logic [1:0] RESP_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational datapath: turns a captured command and its two operands into
// a result word and response code.
module calc1_alu
  import calc1_pkg::*;
(
  input  logic [3:0]  i_cmd,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result,
  output logic [1:0]  o_resp
);

  logic [32:0] w_sum;

  assign w_sum = {1'b0, i_op1} + {1'b0, i_op2};

  always_comb begin
    o_result = 32'd0;
    o_resp   = RESP_INV;
    case (i_cmd)
      CMD_ADD: begin
        if (w_sum[32]) begin
          o_resp = RESP_OVF;
        end else begin
          o_resp   = RESP_OK;
          o_result = w_sum[31:0];
        end
      end
      CMD_SUB: begin
        if (i_op2 > i_op1) begin
          o_resp = RESP_OVF;
        end else begin
          o_resp   = RESP_OK;
          o_result = i_op1 - i_op2;
        end
      end
      // Shift amount is the low five bits of operand 2; upper bits are ignored.
      CMD_SHL: begin
        o_resp   = RESP_OK;
        o_result = i_op1 << i_op2[4:0];
      end
      CMD_SHR: begin
        o_resp   = RESP_OK;
        o_result = i_op1 >> i_op2[4:0];
      end
      default: begin
        o_resp   = RESP_INV;
        o_result = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_responder.sv
// Two-cycle command/operand capture, fixed-latency execute and a one-cycle
// registered response.
//   state | meaning
//   IDLE  | waiting for a nonzero command; captures command and operand 1
//   OP2   | captures operand 2, loads the latency down-counter
//   EXEC  | counting down; result is registered on the last count
//   RESP  | response and result on the outputs for one cycle
module calc1_responder
  import calc1_pkg::*;
#(
  parameter int RESP_LATENCY = DEFAULT_RESP_LATENCY
) (
  input  logic        c_clk,
  input  logic        reset_n,
  input  logic [0:3]  cmd_in,
  input  logic [0:31] data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data
);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cmd;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_cnt;
  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic [31:0] w_alu_result;
  logic [1:0]  w_alu_resp;
  logic [3:0]  w_cmd_in;

  assign w_cmd_in = cmd_in;

  calc1_alu u_alu (
    .i_cmd    (r_cmd),
    .i_op1    (r_op1),
    .i_op2    (r_op2),
    .o_result (w_alu_result),
    .o_resp   (w_alu_resp)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_in != CMD_NONE) w_next_state = ST_OP2;
      ST_OP2:  w_next_state = ST_EXEC;
      // Counter starts at RESP_LATENCY-1, so leaving on count 1 puts RESP
      // exactly RESP_LATENCY cycles after the operand-2 cycle.
      ST_EXEC: if (r_cnt <= 4'd1) w_next_state = ST_RESP;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NONE;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_cnt   <= 4'd0;
      r_resp  <= RESP_NONE;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_in != CMD_NONE) begin
            r_cmd <= w_cmd_in;
            r_op1 <= data_in;
          end
        end
        ST_OP2: begin
          r_op2 <= data_in;
          r_cnt <= 4'(RESP_LATENCY - 1);
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_next_state == ST_RESP) begin
            r_resp <= w_alu_resp;
            r_data <= w_alu_result;
          end
        end
        ST_RESP: begin
          r_resp <= RESP_NONE;
          r_data <= 32'd0;
        end
        default: begin
          r_resp <= RESP_NONE;
          r_data <= 32'd0;
        end
      endcase
    end
  end

  assign out_resp = r_resp;
  assign out_data = r_data;

endmodule

// File: tb/tb_calc1_responder.sv
// Directed bench for calc1_responder: vector table of single transactions plus
// hand-written busy-drop and reset-abort sequences.
module tb_calc1_responder;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  logic        c_clk;
  logic        reset_n;
  logic [0:3]  cmd_in;
  logic [0:31] data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;

  int n_pass;
  int n_total;

  calc1_responder #(.RESP_LATENCY(3)) dut (
    .c_clk    (c_clk),
    .reset_n  (reset_n),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .out_resp (out_resp),
    .out_data (out_data)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Drives one command/operand pair, then watches for the response.
  task automatic run_txn(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    int lat;
    logic [1:0]  gr;
    logic [31:0] gd;
    @(negedge c_clk);
    cmd_in  = c;
    data_in = a;
    @(negedge c_clk);
    cmd_in  = 4'd0;
    data_in = b;
    lat = 99;
    gr  = 2'b00;
    gd  = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge c_clk);
      if (out_resp != 2'b00) begin
        lat = i;
        gr  = out_resp;
        gd  = out_data;
        break;
      end
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " resp"}, {30'd0, gr}, {30'd0, er});
    chk({nm, " data"}, gd, ed);
    if (lat != 99) begin
      @(negedge c_clk);
      chk({nm, " resp cleared"}, {30'd0, out_resp}, 32'd0);
      chk({nm, " data cleared"}, out_data, 32'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int cnt;
    logic [31:0] seen_data;
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    cmd_in  = 4'd0;
    data_in = 32'd0;

    for (int k = 0; k <= 30; k++)
      vecs.push_back('{4'd1, 32'd1 << k, 32'd0, 2'b01, 32'd1 << k});
    vecs.push_back('{4'd1, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd0});
    vecs.push_back('{4'd1, 32'hFFFF_FFFE, 32'd1, 2'b01, 32'hFFFF_FFFF});
    vecs.push_back('{4'd2, 32'd5, 32'd7, 2'b10, 32'd0});
    vecs.push_back('{4'd2, 32'd7, 32'd5, 2'b01, 32'd2});
    vecs.push_back('{4'd2, 32'd9, 32'd9, 2'b01, 32'd0});
    vecs.push_back('{4'd5, 32'd1, 32'd31, 2'b01, 32'h8000_0000});
    vecs.push_back('{4'd6, 32'h8000_0000, 32'h0000_0021, 2'b01, 32'h4000_0000});
    vecs.push_back('{4'd5, 32'h8000_0000, 32'd1, 2'b01, 32'd0});
    vecs.push_back('{4'd5, 32'h0000_00F0, 32'hFFFF_FFE4, 2'b01, 32'h0000_0F00});
    vecs.push_back('{4'd3, 32'd4, 32'd4, 2'b11, 32'd0});
    vecs.push_back('{4'd15, 32'd1, 32'd2, 2'b11, 32'd0});

    #1;
    chk("reset resp", {30'd0, out_resp}, 32'd0);
    chk("reset data", out_data, 32'd0);
    repeat (2) @(negedge c_clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_txn($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].op1, vecs[i].op2,
              vecs[i].resp, vecs[i].data);

    // Busy: a second add issued during EXEC must be dropped.
    @(negedge c_clk);
    cmd_in = 4'd1; data_in = 32'd10;
    @(negedge c_clk);
    cmd_in = 4'd0; data_in = 32'd20;
    @(negedge c_clk);
    cmd_in = 4'd1; data_in = 32'd100;
    @(negedge c_clk);
    cmd_in = 4'd0; data_in = 32'd200;
    cnt = 0;
    seen_data = 32'd0;
    for (int i = 0; i < 12; i++) begin
      if (out_resp != 2'b00) begin
        cnt++;
        seen_data = out_data;
      end
      @(negedge c_clk);
    end
    chk("busy response count", cnt, 1);
    chk("busy data", seen_data, 32'd30);

    // Reset during EXEC aborts the transaction silently.
    cmd_in = 4'd1; data_in = 32'd7;
    @(negedge c_clk);
    cmd_in = 4'd0; data_in = 32'd8;
    @(negedge c_clk);
    reset_n = 1'b0;
    @(negedge c_clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge c_clk);
      if (out_resp != 2'b00) cnt++;
    end
    chk("abort no response", cnt, 0);

    // Reset while the response is showing clears the outputs immediately.
    cmd_in = 4'd1; data_in = 32'd40;
    @(negedge c_clk);
    cmd_in = 4'd0; data_in = 32'd2;
    repeat (3) @(negedge c_clk);
    chk("resp before async reset", {30'd0, out_resp}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async reset resp", {30'd0, out_resp}, 32'd0);
    chk("async reset data", out_data, 32'd0);
    @(negedge c_clk);
    reset_n = 1'b1;

    run_txn("post-reset add", 4'd1, 32'd2, 32'd3, 2'b01, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
